// File: rtl/fwd_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_if
//   Bundles every pipeline-side signal of fwd_hazard_unit so the unit can be
//   wired between ID/EX and the ALU with a single port.
//
//   Modports
//     master : pipeline side; drives the ID / ID-EX / EX-MEM / MEM-WB / MD
//              issue fields and observes forwarding selects, operands, stall
//              controls and MD scoreboard status.
//     slave  : fwd_hazard_unit side (directions mirrored).
//
//   Signal groups
//     ID stage     : id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op
//     ID/EX        : ex_rs, ex_rt, ex_rs_data, ex_rt_data,
//                    ex_rd, ex_write, ex_is_load
//     EX/MEM       : ex_mem_rd, ex_mem_write, ex_mem_data
//     MEM/WB       : mem_wb_rd, mem_wb_write, mem_wb_data
//     MD issue     : md_start, md_rd
//     Outputs      : fwd_a, fwd_b, op_a, op_b, stall, flush_ex,
//                    md_busy, md_done, md_done_rd, md_overrun
//     Optional     : stall_cycles (only when FWD_STALL_CNT_EN is defined)
// ---------------------------------------------------------------------------
interface fwd_hazard_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_md_op;

  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_write;
  logic              ex_is_load;

  logic [ADDR_W-1:0] ex_mem_rd;
  logic              ex_mem_write;
  logic [DATA_W-1:0] ex_mem_data;

  logic [ADDR_W-1:0] mem_wb_rd;
  logic              mem_wb_write;
  logic [DATA_W-1:0] mem_wb_data;

  logic              md_start;
  logic [ADDR_W-1:0] md_rd;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              stall;
  logic              flush_ex;
  logic              md_busy;
  logic              md_done;
  logic [ADDR_W-1:0] md_done_rd;
  logic              md_overrun;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op,
    output ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_rd, ex_write, ex_is_load,
    output ex_mem_rd, ex_mem_write, ex_mem_data,
    output mem_wb_rd, mem_wb_write, mem_wb_data,
    output md_start, md_rd,
    input  fwd_a, fwd_b, op_a, op_b, stall, flush_ex,
    input  md_busy, md_done, md_done_rd, md_overrun
`ifdef FWD_STALL_CNT_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op,
    input  ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_rd, ex_write, ex_is_load,
    input  ex_mem_rd, ex_mem_write, ex_mem_data,
    input  mem_wb_rd, mem_wb_write, mem_wb_data,
    input  md_start, md_rd,
    output fwd_a, fwd_b, op_a, op_b, stall, flush_ex,
    output md_busy, md_done, md_done_rd, md_overrun
`ifdef FWD_STALL_CNT_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Operand forwarding, load-use stall detection and a single-entry
//   multiply/divide scoreboard for a classic 5-stage pipeline. Sits between
//   the ID/EX register and the ALU inputs and drives the IF/ID hold (stall)
//   and ID/EX bubble (flush_ex) controls.
//
//   Parameters
//     ADDR_W : register address width (register 0 reads as zero and is never
//              forwarded or scoreboarded)
//     DATA_W : operand width
//     MD_LAT : MD latency in cycles from acceptance to writeback, 2..16
//
//   Ports
//     clk    : pipeline clock
//     rst_n  : asynchronous active-low reset
//     bus    : fwd_hazard_unit_if.slave, all pipeline-side signals
//
//   Optional feature (macro FWD_STALL_CNT_EN)
//     When defined, bus.stall_cycles counts cycles with stall=1, saturating
//     at 0xFFFFFFFF and cleared by rst_n. When undefined the counter and the
//     signal do not exist.
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int MD_LAT = 4
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  // Counter reload: the first BUSY cycle already counts as one latency cycle.
  localparam logic [3:0] LAT_M1  = 4'(MD_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  // Forward select for one source operand; EX/MEM is the younger result and
  // therefore wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] src,
    input logic              mem_write,
    input logic [ADDR_W-1:0] mem_rd,
    input logic              wb_write,
    input logic [ADDR_W-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (mem_write && (mem_rd != '0) && (mem_rd == src)) begin
      sel = SEL_MEM;
    end else if (wb_write && (wb_rd != '0) && (wb_rd == src)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  function automatic logic [DATA_W-1:0] op_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf_data,
    input logic [DATA_W-1:0] mem_data,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] res;
    case (sel)
      SEL_MEM: res = mem_data;
      SEL_WB:  res = wb_data;
      default: res = rf_data;
    endcase
    return res;
  endfunction

  // True when the ID instruction actually reads register dst.
  function automatic logic id_reads(
    input logic [ADDR_W-1:0] dst,
    input logic              uses_rs,
    input logic [ADDR_W-1:0] rs,
    input logic              uses_rt,
    input logic [ADDR_W-1:0] rt
  );
    return (dst != '0) && ((uses_rs && (rs == dst)) || (uses_rt && (rt == dst)));
  endfunction

`ifdef FWD_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : (val + 32'd1);
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Forwarding and operand muxing (combinational)
  // -------------------------------------------------------------------------
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  always_comb begin
    w_fwd_a = fwd_sel(bus.ex_rs, bus.ex_mem_write, bus.ex_mem_rd,
                      bus.mem_wb_write, bus.mem_wb_rd);
    w_fwd_b = fwd_sel(bus.ex_rt, bus.ex_mem_write, bus.ex_mem_rd,
                      bus.mem_wb_write, bus.mem_wb_rd);
  end

  assign bus.fwd_a = w_fwd_a;
  assign bus.fwd_b = w_fwd_b;
  assign bus.op_a  = op_mux(w_fwd_a, bus.ex_rs_data, bus.ex_mem_data, bus.mem_wb_data);
  assign bus.op_b  = op_mux(w_fwd_b, bus.ex_rt_data, bus.ex_mem_data, bus.mem_wb_data);

  // -------------------------------------------------------------------------
  // MD scoreboard FSM (state, counter and status outputs all registered)
  // -------------------------------------------------------------------------
  md_state_t         r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_pend_rd;
  logic              r_md_done;
  logic [ADDR_W-1:0] r_md_done_rd;
  logic              r_md_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_pend_rd    <= '0;
      r_md_done    <= 1'b0;
      r_md_done_rd <= '0;
      r_md_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_md_done    <= 1'b0;
          r_md_done_rd <= '0;
          if (bus.md_start) begin
            r_state   <= S_BUSY;
            r_cnt     <= LAT_M1;
            r_pend_rd <= bus.md_rd;
          end
        end
        S_BUSY: begin
          // A second issue while occupied is dropped; only the flag records it.
          if (bus.md_start) begin
            r_md_overrun <= 1'b1;
          end
          if (r_cnt == 4'd0) begin
            r_state      <= S_IDLE;
            r_md_done    <= 1'b0;
            r_md_done_rd <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // Pre-compute the done pulse so it lines up with cnt reaching 0.
            if (r_cnt == 4'd1) begin
              r_md_done    <= 1'b1;
              r_md_done_rd <= r_pend_rd;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  logic w_md_busy;
  assign w_md_busy = (r_state == S_BUSY);

  assign bus.md_busy    = w_md_busy;
  assign bus.md_done    = r_md_done;
  assign bus.md_done_rd = r_md_done_rd;
  assign bus.md_overrun = r_md_overrun;

  // -------------------------------------------------------------------------
  // Hazard detection and bubble control (combinational)
  // -------------------------------------------------------------------------
  logic w_load_use;
  logic w_md_stall;
  logic w_stall;

  always_comb begin
    w_load_use = bus.ex_is_load && bus.ex_write &&
                 id_reads(bus.ex_rd, bus.id_uses_rs, bus.id_rs,
                          bus.id_uses_rt, bus.id_rt);
    // Held through the md_done cycle: the regfile only holds the result
    // after the md_done edge.
    w_md_stall = w_md_busy &&
                 (bus.id_md_op ||
                  id_reads(r_pend_rd, bus.id_uses_rs, bus.id_rs,
                           bus.id_uses_rt, bus.id_rt));
    w_stall    = w_load_use || w_md_stall;
  end

  assign bus.stall    = w_stall;
  assign bus.flush_ex = w_stall;

`ifdef FWD_STALL_CNT_EN
  // -------------------------------------------------------------------------
  // Stall cycle counter
  // -------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall) begin
      r_stall_cycles <= sat_inc(r_stall_cycles);
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;

  fwd_hazard_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fwd_hazard_unit #(.ADDR_W(AW), .DATA_W(DW), .MD_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model of the MD unit: number of cycles still to go (0 = idle).
  int          m_rem;
  int          m_pend;
  bit          m_ovr;
  longint      m_stall_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int src);
    if (bus.ex_mem_write && bus.ex_mem_rd != 0 && int'(bus.ex_mem_rd) == src) return 2'b10;
    if (bus.mem_wb_write && bus.mem_wb_rd != 0 && int'(bus.mem_wb_rd) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] ref_op(input logic [1:0] sel, input logic [DW-1:0] rf);
    if (sel == 2'b10) return bus.ex_mem_data;
    if (sel == 2'b01) return bus.mem_wb_data;
    return rf;
  endfunction

  function automatic bit id_reads(input int r);
    return r != 0 && ((bus.id_uses_rs && int'(bus.id_rs) == r) ||
                      (bus.id_uses_rt && int'(bus.id_rt) == r));
  endfunction

  function automatic bit ref_stall();
    bit lu;
    bit md;
    lu = bus.ex_is_load && bus.ex_write && id_reads(int'(bus.ex_rd));
    md = (m_rem > 0) && (bus.id_md_op || id_reads(m_pend));
    return lu || md;
  endfunction

  task automatic model_reset();
    m_rem = 0;
    m_pend = 0;
    m_ovr = 0;
    m_stall_cnt = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ref_stall() && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (m_rem > 0) begin
        if (bus.md_start) m_ovr = 1;
        m_rem--;
      end else if (bus.md_start) begin
        m_rem  = LAT;
        m_pend = int'(bus.md_rd);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] ea;
    logic [1:0] eb;
    ea = ref_fwd(int'(bus.ex_rs));
    eb = ref_fwd(int'(bus.ex_rt));
    chk({tag, ".fwd_a"}, 64'(bus.fwd_a), 64'(ea));
    chk({tag, ".fwd_b"}, 64'(bus.fwd_b), 64'(eb));
    chk({tag, ".op_a"}, 64'(bus.op_a), 64'(ref_op(ea, bus.ex_rs_data)));
    chk({tag, ".op_b"}, 64'(bus.op_b), 64'(ref_op(eb, bus.ex_rt_data)));
    chk({tag, ".stall"}, 64'(bus.stall), 64'(ref_stall()));
    chk({tag, ".flush_ex"}, 64'(bus.flush_ex), 64'(ref_stall()));
    chk({tag, ".md_busy"}, 64'(bus.md_busy), 64'(m_rem > 0));
    chk({tag, ".md_done"}, 64'(bus.md_done), 64'(m_rem == 1));
    if (m_rem == 1) chk({tag, ".md_done_rd"}, 64'(bus.md_done_rd), 64'(m_pend));
    chk({tag, ".md_overrun"}, 64'(bus.md_overrun), 64'(m_ovr));
`ifdef FWD_STALL_CNT_EN
    chk({tag, ".stall_cycles"}, 64'(bus.stall_cycles), 64'(m_stall_cnt));
`endif
  endtask

  task automatic clear_inputs();
    bus.id_rs = '0;        bus.id_rt = '0;
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0; bus.id_md_op = 1'b0;
    bus.ex_rs = '0;        bus.ex_rt = '0;
    bus.ex_rs_data = '0;   bus.ex_rt_data = '0;
    bus.ex_rd = '0;        bus.ex_write = 1'b0; bus.ex_is_load = 1'b0;
    bus.ex_mem_rd = '0;    bus.ex_mem_write = 1'b0; bus.ex_mem_data = '0;
    bus.mem_wb_rd = '0;    bus.mem_wb_write = 1'b0; bus.mem_wb_data = '0;
    bus.md_start = 1'b0;   bus.md_rd = '0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.md_busy", 64'(bus.md_busy), 64'd0);
    chk("rst.md_done", 64'(bus.md_done), 64'd0);
    chk("rst.md_done_rd", 64'(bus.md_done_rd), 64'd0);
    chk("rst.md_overrun", 64'(bus.md_overrun), 64'd0);
    chk("rst.stall", 64'(bus.stall), 64'd0);
    chk("rst.fwd_a", 64'(bus.fwd_a), 64'd0);
    check_all("rst");
    rst_n = 1'b1;
    tick();

    // EX/MEM wins over MEM/WB
    bus.ex_mem_rd = 5'd3; bus.ex_mem_write = 1'b1; bus.ex_mem_data = 32'hAAAA;
    bus.mem_wb_rd = 5'd3; bus.mem_wb_write = 1'b1; bus.mem_wb_data = 32'h5555;
    bus.ex_rs = 5'd3; bus.ex_rs_data = 32'h1234;
    #1;
    chk("prio.fwd_a", 64'(bus.fwd_a), 64'b10);
    chk("prio.op_a", 64'(bus.op_a), 64'hAAAA);
    check_all("prio");
    tick();

    // MEM/WB only
    bus.ex_mem_write = 1'b0;
    #1;
    chk("wb.fwd_a", 64'(bus.fwd_a), 64'b01);
    chk("wb.op_a", 64'(bus.op_a), 64'h5555);
    tick();

    // r0 never forwarded
    clear_inputs();
    bus.ex_rt = 5'd0; bus.ex_mem_rd = 5'd0; bus.ex_mem_write = 1'b1;
    bus.ex_mem_data = 32'hDEAD_BEEF; bus.ex_rt_data = 32'd0;
    #1;
    chk("r0.fwd_b", 64'(bus.fwd_b), 64'b00);
    chk("r0.op_b", 64'(bus.op_b), 64'd0);
    tick();

    // Load-use on rt: one stall cycle, then the load is in MEM
    clear_inputs();
    bus.ex_is_load = 1'b1; bus.ex_write = 1'b1; bus.ex_rd = 5'd5;
    bus.id_rt = 5'd5; bus.id_uses_rt = 1'b1;
    #1;
    chk("lu.stall", 64'(bus.stall), 64'd1);
    chk("lu.flush_ex", 64'(bus.flush_ex), 64'd1);
    check_all("lu");
    tick();
    clear_inputs();
    bus.id_rt = 5'd5; bus.id_uses_rt = 1'b1;
    bus.ex_rt = 5'd5; bus.ex_rt_data = 32'h0BAD;
    bus.ex_mem_rd = 5'd5; bus.ex_mem_write = 1'b1; bus.ex_mem_data = 32'hC0DE;
    #1;
    chk("lu2.stall", 64'(bus.stall), 64'd0);
    chk("lu2.fwd_b", 64'(bus.fwd_b), 64'b10);
    chk("lu2.op_b", 64'(bus.op_b), 64'hC0DE);
    tick();

    // Load-use ignored when the ID instruction does not use that operand
    clear_inputs();
    bus.ex_is_load = 1'b1; bus.ex_write = 1'b1; bus.ex_rd = 5'd5;
    bus.id_rt = 5'd5; bus.id_uses_rt = 1'b0;
    #1;
    chk("lu_nouse.stall", 64'(bus.stall), 64'd0);
    tick();

    // MD op to r7, ID reads r7: busy 4 cycles, done in cycle 4, stall until cycle 5
    clear_inputs();
    bus.md_start = 1'b1; bus.md_rd = 5'd7;
    #1;
    check_all("md_issue");
    tick();
    bus.md_start = 1'b0; bus.id_rs = 5'd7; bus.id_uses_rs = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("md.c%0d.busy", c), 64'(bus.md_busy), 64'(c <= 4));
      chk($sformatf("md.c%0d.done", c), 64'(bus.md_done), 64'(c == 4));
      chk($sformatf("md.c%0d.stall", c), 64'(bus.stall), 64'(c <= 4));
      if (c == 4) chk("md.done_rd", 64'(bus.md_done_rd), 64'd7);
      check_all($sformatf("md.c%0d", c));
      tick();
    end

    // Load-use and MD stall together: single stall
    clear_inputs();
    bus.md_start = 1'b1; bus.md_rd = 5'd2;
    tick();
    bus.md_start = 1'b0; bus.id_md_op = 1'b1;
    bus.ex_is_load = 1'b1; bus.ex_write = 1'b1; bus.ex_rd = 5'd6;
    bus.id_rs = 5'd6; bus.id_uses_rs = 1'b1;
    #1;
    chk("both.stall", 64'(bus.stall), 64'd1);
    chk("both.flush_ex", 64'(bus.flush_ex), 64'd1);
    check_all("both");
    clear_inputs();
    repeat (5) tick();

    // Overrun: second issue ignored, flag sticky until reset
    bus.md_start = 1'b1; bus.md_rd = 5'd9;
    tick();
    bus.md_rd = 5'd12;
    #1;
    check_all("ovr.c1");
    tick();
    bus.md_start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      #1;
      chk($sformatf("ovr.c%0d.overrun", c), 64'(bus.md_overrun), 64'd1);
      if (c == 4) begin
        chk("ovr.done", 64'(bus.md_done), 64'd1);
        chk("ovr.done_rd", 64'(bus.md_done_rd), 64'd9);
      end
      check_all($sformatf("ovr.c%0d", c));
      tick();
    end
    repeat (100) tick();
    chk("ovr.sticky", 64'(bus.md_overrun), 64'd1);
    check_all("ovr.late");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ovr.rst", 64'(bus.md_overrun), 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // Asynchronous reset two cycles into BUSY
    bus.md_start = 1'b1; bus.md_rd = 5'd3;
    tick();
    bus.md_start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst.md_busy", 64'(bus.md_busy), 64'd0);
    chk("mrst.md_done", 64'(bus.md_done), 64'd0);
    check_all("mrst");
    #2 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("mrst.after%0d.done", c), 64'(bus.md_done), 64'd0);
      chk($sformatf("mrst.after%0d.busy", c), 64'(bus.md_busy), 64'd0);
    end

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bus.id_rs        = AW'($urandom_range(0, 7));
      bus.id_rt        = AW'($urandom_range(0, 7));
      bus.id_uses_rs   = 1'($urandom_range(0, 1));
      bus.id_uses_rt   = 1'($urandom_range(0, 1));
      bus.id_md_op     = ($urandom_range(0, 5) == 0);
      bus.ex_rs        = AW'($urandom_range(0, 7));
      bus.ex_rt        = AW'($urandom_range(0, 7));
      bus.ex_rs_data   = $urandom;
      bus.ex_rt_data   = $urandom;
      bus.ex_rd        = AW'($urandom_range(0, 7));
      bus.ex_write     = 1'($urandom_range(0, 1));
      bus.ex_is_load   = 1'($urandom_range(0, 1));
      bus.ex_mem_rd    = AW'($urandom_range(0, 7));
      bus.ex_mem_write = 1'($urandom_range(0, 1));
      bus.ex_mem_data  = $urandom;
      bus.mem_wb_rd    = AW'($urandom_range(0, 7));
      bus.mem_wb_write = 1'($urandom_range(0, 1));
      bus.mem_wb_data  = $urandom;
      bus.md_start     = ($urandom_range(0, 7) == 0);
      bus.md_rd        = AW'($urandom_range(0, 7));
      #1;
      check_all($sformatf("rnd%0d", i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
